// File: rtl/ofdm_fch_mod_gen_if.sv
// FCH generator bus: start/header fields in, BPSK sample stream plus status out.
// Latency: none, wires only.
// Backpressure: a sample moves only when o_valid and i_wayt_output_data are both high.
//
// master : the FCH generator (drives o_* and samples i_*)
// slave  : frame controller / IFFT side (drives i_* and samples o_*)
//   i_start             single-cycle request for one FCH symbol
//   i_data_frame_size   8-bit frame size field, sampled with i_start
//   i_mode              2-bit mode field, sampled with i_start
//   i_wayt_output_data  downstream accept
//   o_data_i / o_data_q DATA_SIZE-bit I/Q sample (Q is always zero)
//   o_valid             sample valid
//   o_fch_counter       samples accepted in the current FCH
//   o_busy / o_done     status: not idle / end-of-symbol pulse
interface ofdm_fch_mod_gen_if #(
    parameter int DATA_SIZE = 16
);
    logic                 i_start;
    logic [7:0]           i_data_frame_size;
    logic [1:0]           i_mode;
    logic                 i_wayt_output_data;
    logic [DATA_SIZE-1:0] o_data_i;
    logic [DATA_SIZE-1:0] o_data_q;
    logic                 o_valid;
    logic [15:0]          o_fch_counter;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        input  i_start, i_data_frame_size, i_mode, i_wayt_output_data,
        output o_data_i, o_data_q, o_valid, o_fch_counter, o_busy, o_done
    );

    modport slave (
        output i_start, i_data_frame_size, i_mode, i_wayt_output_data,
        input  o_data_i, o_data_q, o_valid, o_fch_counter, o_busy, o_done
    );
endinterface

// File: rtl/ofdm_fch_mod_gen.sv
// FCH symbol generator: latches {mode, 6'b0, frame_size, crc8}, repeats it REPEAT times and BPSK-maps it.
// Latency: i_start in cycle 0 gives the first valid sample (k=0) in cycle 2.
// Backpressure: while o_valid && !i_wayt_output_data the sample and o_valid hold and k stalls.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset; abandons any partial symbol without o_done
//   bus        ofdm_fch_mod_gen_if.master (start/fields in, I/Q samples and status out)
// Optional build macro OFDM_FCH_SCRAMBLE_EN: XOR each header bit with a x^7+x^4+1 PRBS
// (seed 7'h7F at LOAD, output s[6]^s[3], advanced once per accepted header sample).
module ofdm_fch_mod_gen #(
    parameter int          DATA_SIZE  = 16,
    parameter int          N_CARRIERS = 64,
    parameter int          REPEAT     = 2,
    parameter logic [15:0] AMPLITUDE  = 16'h5A82
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    ofdm_fch_mod_gen_if.master   bus
);

    localparam int KW = $clog2(N_CARRIERS);

    // Header-carrier count and last index, sized so the compares below are width-exact.
    localparam logic [KW:0]   HDR_LEN = (KW+1)'(24 * REPEAT);
    localparam logic [KW-1:0] K_LAST  = KW'(N_CARRIERS - 1);

    // Sign-extend or truncate the 16-bit amplitude to the sample width.
    localparam logic [DATA_SIZE-1:0] AMP_POS = DATA_SIZE'($signed(AMPLITUDE));
    localparam logic [DATA_SIZE-1:0] AMP_NEG = DATA_SIZE'(0) - AMP_POS;

    generate
        if (N_CARRIERS < 24 * REPEAT) begin : g_bad_carriers
            $error("ofdm_fch_mod_gen: N_CARRIERS must be >= 24*REPEAT");
        end
        if (REPEAT < 1 || REPEAT > 4) begin : g_bad_repeat
            $error("ofdm_fch_mod_gen: REPEAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    // CRC-8, poly 0x07, init 0x00, MSB-first over the 16 upper header bits.
    function automatic logic [7:0] crc8(input logic [15:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Header carriers carry +/-AMPLITUDE (bit 1 -> negative); the rest are null carriers.
    function automatic logic [DATA_SIZE-1:0] map_sample(
        input logic [23:0] hdr,
        input logic [4:0]  idx,
        input logic        in_hdr,
        input logic        scr
    );
        logic b;
        b = hdr[5'd23 - idx] ^ scr;
        if (!in_hdr) return '0;
        return b ? AMP_NEG : AMP_POS;
    endfunction

    state_t               state_q;
    logic [23:0]          hdr_q;
    logic [KW-1:0]        k_q;
    logic [4:0]           idx_q;      // k mod 24, kept as its own wrapping counter
    logic [DATA_SIZE-1:0] data_i_q;
    logic                 valid_q;
    logic [15:0]          cnt_q;
    logic                 busy_q;
    logic                 done_q;

    logic [15:0]          hdr_hi;
    logic [KW-1:0]        k_d;
    logic [4:0]           idx_d;
    logic [DATA_SIZE-1:0] data_i_d;
    logic                 accept;
    logic                 scr_seed;
    logic                 scr_d;

`ifdef OFDM_FCH_SCRAMBLE_EN
    localparam logic [6:0] PRBS_SEED = 7'h7F;
    logic [6:0] prbs_q;
    logic [6:0] prbs_d;
`endif

    assign hdr_hi = {bus.i_mode, 6'b0, bus.i_data_frame_size};
    assign accept = valid_q && bus.i_wayt_output_data;

    // Next-sample datapath: values that take effect when the current sample is accepted.
    always_comb begin
        k_d      = k_q + 1'b1;
        idx_d    = (idx_q == 5'd23) ? 5'd0 : idx_q + 5'd1;
`ifdef OFDM_FCH_SCRAMBLE_EN
        // PRBS only steps on header carriers, so null carriers never consume sequence bits.
        prbs_d   = ({1'b0, k_q} < HDR_LEN) ? {prbs_q[5:0], prbs_q[6] ^ prbs_q[3]} : prbs_q;
        scr_d    = prbs_d[6] ^ prbs_d[3];
        scr_seed = PRBS_SEED[6] ^ PRBS_SEED[3];
`else
        scr_d    = 1'b0;
        scr_seed = 1'b0;
`endif
        data_i_d = map_sample(hdr_q, idx_d, ({1'b0, k_d} < HDR_LEN), scr_d);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            hdr_q    <= '0;
            k_q      <= '0;
            idx_q    <= '0;
            data_i_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef OFDM_FCH_SCRAMBLE_EN
            prbs_q   <= PRBS_SEED;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.i_start) begin
                        hdr_q   <= {hdr_hi, crc8(hdr_hi)};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    k_q      <= '0;
                    idx_q    <= '0;
`ifdef OFDM_FCH_SCRAMBLE_EN
                    prbs_q   <= PRBS_SEED;
`endif
                    // Sample 0 is always a header carrier since N_CARRIERS >= 24*REPEAT >= 24.
                    data_i_q <= map_sample(hdr_q, 5'd0, 1'b1, scr_seed);
                    valid_q  <= 1'b1;
                    state_q  <= SEND;
                end
                SEND: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (k_q == K_LAST) begin
                            valid_q  <= 1'b0;
                            data_i_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            k_q      <= k_d;
                            idx_q    <= idx_d;
`ifdef OFDM_FCH_SCRAMBLE_EN
                            prbs_q   <= prbs_d;
`endif
                            data_i_q <= data_i_d;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_data_i      = data_i_q;
    assign bus.o_data_q      = '0;
    assign bus.o_valid       = valid_q;
    assign bus.o_fch_counter = cnt_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;

endmodule

// File: tb/tb_ofdm_fch_mod_gen.sv
// Directed bench for ofdm_fch_mod_gen (defaults: 16-bit samples, 64 carriers, REPEAT=2).
// Latency: first valid sample expected two cycles after the start pulse.
// Backpressure: exercised with a fixed ready pattern; stalled samples must hold.
module tb_ofdm_fch_mod_gen;
    localparam int          NC  = 64;
    localparam int          HL  = 48;
    localparam logic [15:0] POS = 16'h5A82;
    localparam logic [15:0] NEG = 16'hA57E;

    // Hand-computed headers: {mode, 6'b0, frame_size, crc8}.
    localparam logic [23:0] HDR_ZERO = 24'h000000;   // mode 0, fs 00, crc 00
    localparam logic [23:0] HDR_FF   = 24'hC0FF1E;   // mode 3, fs FF, crc 1E
    localparam logic [23:0] HDR_01   = 24'h8001B1;   // mode 2, fs 01, crc B1

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ofdm_fch_mod_gen_if #(.DATA_SIZE(16)) bus ();

    ofdm_fch_mod_gen #(
        .DATA_SIZE(16), .N_CARRIERS(NC), .REPEAT(2), .AMPLITUDE(16'h5A82)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [6:0] sign_log;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_i(input logic [23:0] hdr, input int k, input logic scr);
        if (k >= HL) return 16'h0000;
        return (hdr[23 - (k % 24)] ^ scr) ? NEG : POS;
    endfunction

    task automatic start_sym(input logic [1:0] m, input logic [7:0] fs);
        @(negedge clk);
        bus.i_mode            = m;
        bus.i_data_frame_size = fs;
        bus.i_start           = 1'b1;
    endtask

    // Follows one symbol from the cycle after the start pulse.
    // stall: apply ready pattern; inj_k: pulse i_start at that k; rst_k: assert reset at that k.
    task automatic collect(input logic [23:0] hdr, input bit stall, input int inj_k,
                           input int rst_k, output int nxfer, output int ndone);
        int         k;
        int         first_v;
        bit         prev_stall;
        bit         inj_pend;
        bit         finished;
        logic [15:0] prev_d;
        logic [6:0]  s;
        logic        scr;
        logic [6:0]  pat;
        k = 0; first_v = -1; prev_stall = 0; inj_pend = 0; finished = 0;
        prev_d = '0; s = 7'h7F; pat = 7'b1011001;
        nxfer = 0; ndone = 0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                // Scramble the fields right after start: the symbol must not notice.
                bus.i_start           = 1'b0;
                bus.i_mode            = ~bus.i_mode;
                bus.i_data_frame_size = ~bus.i_data_frame_size;
                chk("load_valid", 32'(bus.o_valid), 32'd0);
                chk("load_busy", 32'(bus.o_busy), 32'd1);
            end
            if (inj_pend) begin
                bus.i_start = 1'b0;
                inj_pend    = 0;
            end
            bus.i_wayt_output_data = stall ? pat[cyc % 7] : 1'b1;
            if (bus.o_done) begin
                ndone++;
                chk("done_valid", 32'(bus.o_valid), 32'd0);
                chk("done_cnt", 32'(bus.o_fch_counter), 32'(NC));
                finished = 1;
                break;
            end
            if (first_v >= 0) chk("valid_steady", 32'(bus.o_valid), 32'd1);
            if (bus.o_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("latency", 32'(cyc), 32'd2);
                end
`ifdef OFDM_FCH_SCRAMBLE_EN
                scr = s[6] ^ s[3];
`else
                scr = 1'b0;
`endif
                if (prev_stall) chk("hold", 32'(bus.o_data_i), 32'(prev_d));
                chk($sformatf("i_k%0d", k), 32'(bus.o_data_i), 32'(exp_i(hdr, k, scr)));
                chk("q_zero", 32'(bus.o_data_q), 32'd0);
                chk($sformatf("cnt_k%0d", k), 32'(bus.o_fch_counter), 32'(k));
                if (k < 7) sign_log[k] = bus.o_data_i[15];
                if (k == inj_k && !inj_pend) begin
                    bus.i_start = 1'b1;
                    inj_pend    = 1;
                end
                if (k == rst_k) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_valid", 32'(bus.o_valid), 32'd0);
                    chk("rst_data", 32'(bus.o_data_i), 32'd0);
                    chk("rst_cnt", 32'(bus.o_fch_counter), 32'd0);
                    chk("rst_busy", 32'(bus.o_busy), 32'd0);
                    finished = 1;
                    break;
                end
                prev_stall = !bus.i_wayt_output_data;
                prev_d     = bus.o_data_i;
                if (bus.i_wayt_output_data) begin
                    nxfer++;
                    if (k < HL) s = {s[5:0], s[6] ^ s[3]};
                    k++;
                end
            end
        end
        if (!finished) chk("timeout", 32'd0, 32'd1);
        bus.i_start = 1'b0;
    endtask

    task automatic after_done;
        @(negedge clk);
        chk("post_done", 32'(bus.o_done), 32'd0);
        chk("post_busy", 32'(bus.o_busy), 32'd0);
        chk("post_cnt", 32'(bus.o_fch_counter), 32'(NC));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nx, nd;
        bus.i_start            = 1'b0;
        bus.i_mode             = 2'd0;
        bus.i_data_frame_size  = 8'h00;
        bus.i_wayt_output_data = 1'b1;
        sign_log               = '0;

        // Reset state.
        #12;
        chk("rst0_valid", 32'(bus.o_valid), 32'd0);
        chk("rst0_busy", 32'(bus.o_busy), 32'd0);
        chk("rst0_done", 32'(bus.o_done), 32'd0);
        chk("rst0_cnt", 32'(bus.o_fch_counter), 32'd0);
        chk("rst0_data", 32'(bus.o_data_i), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero header, ready tied high.
        start_sym(2'd0, 8'h00);
        collect(HDR_ZERO, 1'b0, -1, -1, nx, nd);
        chk("t1_xfers", 32'(nx), 32'(NC));
        chk("t1_dones", 32'(nd), 32'd1);
        after_done();
`ifdef OFDM_FCH_SCRAMBLE_EN
        chk("prbs_first7", 32'(sign_log), 32'b1110000);
`else
        chk("signs_first7", 32'(sign_log), 32'd0);
`endif

        // mode 3, frame size FF.
        start_sym(2'd3, 8'hFF);
        collect(HDR_FF, 1'b0, -1, -1, nx, nd);
        chk("t2_xfers", 32'(nx), 32'(NC));
        chk("t2_dones", 32'(nd), 32'd1);
        after_done();

        // Backpressure pattern.
        start_sym(2'd2, 8'h01);
        collect(HDR_01, 1'b1, -1, -1, nx, nd);
        chk("t3_xfers", 32'(nx), 32'(NC));
        chk("t3_dones", 32'(nd), 32'd1);
        after_done();

        // Start pulse mid-symbol must be ignored.
        start_sym(2'd3, 8'hFF);
        collect(HDR_FF, 1'b0, 10, -1, nx, nd);
        chk("t4_xfers", 32'(nx), 32'(NC));
        chk("t4_dones", 32'(nd), 32'd1);
        after_done();
        chk("t4_no_restart", 32'(bus.o_busy), 32'd0);

        // Asynchronous reset mid-symbol, then a clean symbol.
        start_sym(2'd0, 8'h00);
        collect(HDR_ZERO, 1'b0, -1, 30, nx, nd);
        chk("t5_dones", 32'(nd), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_done", 32'(bus.o_done), 32'd0);
        end
        rst_n = 1'b1;
        start_sym(2'd2, 8'h01);
        collect(HDR_01, 1'b0, -1, -1, nx, nd);
        chk("t5_xfers", 32'(nx), 32'(NC));
        chk("t5_dones2", 32'(nd), 32'd1);
        after_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
